// File: rtl/mips_bus_pkg.sv
// Shared types and bus constants for the two-master MIPS memory arbiter.
// Imported by the arbiter top and its round-robin selector.
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Read data returned to a master whose transaction was aborted by timeout.
    localparam logic [DATA_W-1:0] ABORT_RDATA = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Combinational 2-way round-robin selector: on a tie, picks the master
// that was not granted last.
module mips_bus_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       valid
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        valid = |req;
        pick  = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-MM slave between instruction fetch (M0) and load/store (M1)
// with a registered round-robin grant held for a whole transaction.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit RESET_LAST     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,

    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] wait_cnt_q;

    logic       req0, req1;
    logic       pick, pick_valid;
    logic       in_grant, sel_m1, granted_req;
    logic       done, abort;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    mips_bus_rr_pick u_rr_pick (
        .req   ({req1, req0}),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    assign in_grant    = (state_q != IDLE);
    assign sel_m1      = (state_q == GRANT1);
    assign granted_req = sel_m1 ? req1 : req0;
    assign done        = in_grant && granted_req && !s_waitrequest;
    assign abort       = in_grant && granted_req && s_waitrequest && (wait_cnt_q == WAIT_LIMIT);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = pick ? GRANT1 : GRANT0;
                    last_d  = pick;
                end
            end
            GRANT0, GRANT1: begin
                // A dropped request (protocol violation) also releases the bus.
                if (!granted_req || done || abort) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= RESET_LAST;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Cleared while idle, so it starts from zero on every grant; the abort
    // at WAIT_LIMIT always happens before the counter could overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (!in_grant) begin
            wait_cnt_q <= '0;
        end else if (s_waitrequest) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        grant          = 2'b00;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        timeout_err    = abort;

        if (in_grant) begin
            if (sel_m1) begin
                s_address    = m1_address;
                s_write      = m1_write;
                s_read       = m1_read & ~m1_write;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
                grant        = 2'b10;
                m1_waitrequest = abort ? 1'b0 : s_waitrequest;
                m1_readdata    = abort ? ABORT_RDATA : s_readdata;
            end else begin
                s_address    = m0_address;
                s_write      = m0_write;
                s_read       = m0_read & ~m0_write;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
                grant        = 2'b01;
                m0_waitrequest = abort ? 1'b0 : s_waitrequest;
                m0_readdata    = abort ? ABORT_RDATA : s_readdata;
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed cycle checks plus a randomized two-master run checked by a
// scoreboard against a simple slave/response model.
module tb_mips_bus_arbiter;

    localparam int T_CYC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic [1:0]  grant;
    logic        timeout_err;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(T_CYC), .RESET_LAST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_en   = 1'b0;

    // Slave model: wait states come from a fixed count or from address bits
    // (bit 4 = stall forever, bits 3:2 = wait count); read data is a hash of the address.
    bit          use_fixed = 1'b1;
    int          fixed_waits = 0;
    bit          use_override = 1'b0;
    logic [31:0] rd_override = 32'h0;
    int          wcnt;
    int          waits_now;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb begin
        waits_now     = use_fixed ? fixed_waits : (s_address[4] ? 1000000 : int'(s_address[3:2]));
        s_waitrequest = (s_read | s_write) && (wcnt < waits_now);
        s_readdata    = s_read ? (use_override ? rd_override : rom(s_address)) : 32'h0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) wcnt <= 0;
        else if ((s_read | s_write) && s_waitrequest) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rdata;
        bit          err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          wr;
    } xfer_t;

    resp_t exp_q0[$], exp_q1[$];
    xfer_t sq0[$], sq1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic wait_of(input int m);
        return (m == 1) ? m1_waitrequest : m0_waitrequest;
    endfunction

    task automatic set_master(input int m, input logic [31:0] a, input logic rd, input logic wr,
                              input logic [31:0] wd, input logic [3:0] be);
        if (m == 1) begin
            m1_address = a; m1_read = rd; m1_write = wr; m1_writedata = wd; m1_byteenable = be;
        end else begin
            m0_address = a; m0_read = rd; m0_write = wr; m0_writedata = wd; m0_byteenable = be;
        end
    endtask

    task automatic compare_resp(input int m, input logic [31:0] rdata);
        resp_t e;
        if (m == 1) begin
            if (exp_q1.size() == 0) begin fail_now("m1_resp_unexpected"); return; end
            e = exp_q1.pop_front();
        end else begin
            if (exp_q0.size() == 0) begin fail_now("m0_resp_unexpected"); return; end
            e = exp_q0.pop_front();
        end
        if (e.chk_rdata) check(m ? "m1_readdata" : "m0_readdata", rdata, e.rdata);
        check(m ? "m1_timeout_err" : "m0_timeout_err", {31'b0, timeout_err}, {31'b0, e.err});
    endtask

    task automatic slave_check();
        xfer_t e;
        int    m;
        m = s_address[5] ? 1 : 0;
        if (m == 1) begin
            if (sq1.size() == 0) begin fail_now("slave_xfer_unexpected"); return; end
            e = sq1.pop_front();
        end else begin
            if (sq0.size() == 0) begin fail_now("slave_xfer_unexpected"); return; end
            e = sq0.pop_front();
        end
        check("slave_addr", s_address, e.addr);
        check("slave_rw", {30'b0, s_write, s_read}, e.wr ? 32'd2 : 32'd1);
        check("slave_be", {28'b0, s_byteenable}, {28'b0, e.be});
        if (e.wr) check("slave_wdata", s_writedata, e.wdata);
        check("slave_grant", {30'b0, grant}, (m == 1) ? 32'd2 : 32'd1);
    endtask

    // Scoreboard monitor: pops an expectation whenever a master or the slave completes.
    always @(negedge clk) begin
        if (sb_en) begin
            if ((m0_read | m0_write) && !m0_waitrequest) compare_resp(0, m0_readdata);
            if ((m1_read | m1_write) && !m1_waitrequest) compare_resp(1, m1_readdata);
            if ((s_read | s_write) && !s_waitrequest) slave_check();
        end
    end

    task automatic drive_master(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] r, a, wd;
            logic [3:0]  be;
            bit          wr, stall;
            int          cyc;
            resp_t       e;
            xfer_t       x;
            repeat ($urandom_range(0, 2)) tick();
            r     = $urandom();
            wd    = $urandom();
            be    = 4'($urandom_range(1, 15));
            wr    = ($urandom_range(0, 1) == 1);
            stall = ($urandom_range(0, 7) == 0);
            a     = {r[31:6], (m == 1), stall, r[3:2], 2'b00};
            e.rdata     = stall ? 32'h0 : rom(a);
            e.chk_rdata = !wr || stall;
            e.err       = stall;
            if (m == 1) exp_q1.push_back(e); else exp_q0.push_back(e);
            if (!stall) begin
                x.addr = a; x.wdata = wd; x.be = be; x.wr = wr;
                if (m == 1) sq1.push_back(x); else sq0.push_back(x);
            end
            set_master(m, a, !wr, wr, wd, be);
            cyc = 0;
            while (1) begin
                @(negedge clk);
                if (!wait_of(m)) break;
                cyc++;
                if (cyc > 60) begin
                    fail_now(m ? "m1_no_completion" : "m0_no_completion");
                    break;
                end
            end
            @(posedge clk);
            #1;
            set_master(m, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rr_exp[6];
        rr_exp = '{1, 0, 2, 0, 1, 0};
        reset = 1'b0;
        set_master(0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        set_master(1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        #3;
        check("rst_grant", {30'b0, grant}, 32'd0);
        check("rst_s_strobe", {30'b0, s_read, s_write}, 32'd0);
        check("rst_waitreq", {30'b0, m1_waitrequest, m0_waitrequest}, 32'd3);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Continuous tie: grants alternate with an idle cycle, M0 first.
        set_master(0, 32'h100, 1'b1, 1'b0, 32'h0, 4'hF);
        set_master(1, 32'h200, 1'b1, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check("rr_first_idle", {30'b0, grant}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_grant", {30'b0, grant}, 32'(rr_exp[i]));
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
        tick();

        // Single zero-wait read from the reset vector.
        use_override = 1'b1;
        rd_override  = 32'h2402_0005;
        set_master(0, 32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        check("sm_idle_sread", {31'b0, s_read}, 32'd0);
        check("sm_idle_wait", {31'b0, m0_waitrequest}, 32'd1);
        @(negedge clk);
        check("sm_grant", {30'b0, grant}, 32'd1);
        check("sm_sread", {31'b0, s_read}, 32'd1);
        check("sm_saddr", s_address, 32'hBFC0_0000);
        check("sm_wait", {31'b0, m0_waitrequest}, 32'd0);
        check("sm_rdata", m0_readdata, 32'h2402_0005);
        tick();
        m0_read = 1'b0;
        use_override = 1'b0;
        @(negedge clk);
        check("sm_back_idle", {30'b0, grant}, 32'd0);

        // M1 write with three slave wait states.
        tick();
        fixed_waits = 3;
        set_master(1, 32'h0000_1000, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk);
        check("ws_idle_wait", {31'b0, m1_waitrequest}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ws_swrite", {30'b0, s_read, s_write}, 32'd1);
            check("ws_saddr", s_address, 32'h0000_1000);
            check("ws_sdata", s_writedata, 32'hDEAD_BEEF);
            check("ws_sbe", {28'b0, s_byteenable}, 32'h3);
            check("ws_m1_wait", {31'b0, m1_waitrequest}, (k < 3) ? 32'd1 : 32'd0);
            check("ws_m0_wait", {31'b0, m0_waitrequest}, 32'd1);
        end
        tick();
        m1_write = 1'b0;
        @(negedge clk);
        check("ws_back_idle", {30'b0, grant}, 32'd0);

        // Timeout: slave stalls forever, abort on the 4th granted cycle.
        tick();
        fixed_waits = 1000000;
        set_master(0, 32'h0000_2000, 1'b1, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("to_err", {31'b0, timeout_err}, (k == 3) ? 32'd1 : 32'd0);
            check("to_m0_wait", {31'b0, m0_waitrequest}, (k == 3) ? 32'd0 : 32'd1);
            check("to_sread", {31'b0, s_read}, 32'd1);
            if (k == 3) check("to_rdata", m0_readdata, 32'h0);
        end
        tick();
        m0_read = 1'b0;
        @(negedge clk);
        check("to_back_idle", {30'b0, grant}, 32'd0);
        check("to_err_clear", {31'b0, timeout_err}, 32'd0);

        // Request dropped while granted and stalled; pending M1 follows.
        tick();
        set_master(0, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("rd_grant0", {30'b0, grant}, 32'd1);
        m0_read = 1'b0;
        set_master(1, 32'h0000_4000, 1'b1, 1'b0, 32'h0, 4'hF);
        #1;
        check("rd_no_strobe", {30'b0, s_read, s_write}, 32'd0);
        check("rd_no_err", {31'b0, timeout_err}, 32'd0);
        @(negedge clk);
        check("rd_idle", {30'b0, grant}, 32'd0);
        check("rd_idle_err", {31'b0, timeout_err}, 32'd0);
        @(negedge clk);
        check("rd_grant1", {30'b0, grant}, 32'd2);
        fixed_waits = 0;
        #1;
        check("rd_m1_done", {31'b0, m1_waitrequest}, 32'd0);
        tick();
        m1_read = 1'b0;

        // Asynchronous reset in the middle of a stalled M1 transaction.
        fixed_waits = 1000000;
        set_master(1, 32'h0000_5000, 1'b1, 1'b0, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("ar_grant1", {30'b0, grant}, 32'd2);
        reset = 1'b0;
        #1;
        check("ar_grant", {30'b0, grant}, 32'd0);
        check("ar_sread", {31'b0, s_read}, 32'd0);
        check("ar_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
        m1_read = 1'b0;
        fixed_waits = 0;
        set_master(0, 32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 4'hF);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("ar_release_idle", {30'b0, grant}, 32'd0);
        @(negedge clk);
        check("ar_m0_grant", {30'b0, grant}, 32'd1);
        check("ar_m0_addr", s_address, 32'hBFC0_0000);
        tick();
        m0_read = 1'b0;

        // Randomized concurrent traffic against the scoreboard.
        tick();
        use_fixed = 1'b0;
        sb_en = 1'b1;
        fork
            drive_master(0, 40);
            drive_master(1, 40);
        join
        repeat (6) tick();
        sb_en = 1'b0;
        check("m0_resp_left", 32'(exp_q0.size()), 32'd0);
        check("m1_resp_left", 32'(exp_q1.size()), 32'd0);
        check("m0_xfer_left", 32'(sq0.size()), 32'd0);
        check("m1_xfer_left", 32'(sq1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares one Avalon-MM slave port (unified instruction/data memory) between two Avalon-MM masters.
- M0 is the instruction-fetch requester; M1 is the load/store requester.
- Registered round-robin grant, held for a full transaction. A per-transaction timeout prevents a stalled slave from hanging the CPU.
- Sits between the CPU bus controller(s) and the memory/testbench RAM.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a granted transaction may see s_waitrequest=1 before forced abort; must be >=1.
- RESET_LAST, 1: initial value of last-granted index, so M0 wins the first tie.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- m0_address  input  32  M0 byte address
- m0_read  input  1  M0 read request
- m0_write  input  1  M0 write request
- m0_writedata  input  32  M0 write data
- m0_byteenable  input  4  M0 byte lanes
- m0_waitrequest  output  1  stall to M0
- m0_readdata  output  32  read data to M0
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable  inputs  32/1/1/32/4  M1 request, same meaning as M0
- m1_waitrequest, m1_readdata  outputs  1/32  M1 response, same meaning as M0
- s_address  output  32  to slave
- s_read  output  1  to slave
- s_write  output  1  to slave
- s_writedata  output  32  to slave
- s_byteenable  output  4  to slave
- s_waitrequest  input  1  slave stall
- s_readdata  input  32  slave read data, valid in the cycle s_waitrequest=0
- grant  output  2  one-hot current owner (bit0=M0, bit1=M1), 0 when idle
- timeout_err  output  1  one-cycle pulse on forced abort

Behaviour:
- Request definition: mX_req = mX_read | mX_write. Read and write both high from one master is illegal; write takes priority on s_*.
- States: IDLE, GRANT0, GRANT1.
- IDLE transitions:
  - only M0 requests -> GRANT0
  - only M1 requests -> GRANT1
  - both request -> grant the master != last; update last on every grant
  - none -> stay
- IDLE outputs: s_read=s_write=0; grant=0; s_address/s_writedata/s_byteenable=0; both mX_waitrequest=1.
- GRANTx outputs (combinational, from granted master): s_* driven from mX_*; mX_waitrequest = s_waitrequest; mX_readdata = s_readdata.
- Non-granted master in GRANTx: waitrequest=1, readdata=0.
- Completion: in GRANTx, mX_req=1 and s_waitrequest=0 -> transfer completes this cycle -> next state IDLE.
- One mandatory idle cycle between transactions.
- Latency: request first seen in IDLE at cycle N gives s_read/s_write at N+1. Zero-wait slave completes at N+1.
- Master drops request while granted (protocol violation): return to IDLE next cycle, no error, no slave strobe that cycle.
- Timeout:
  - wait_cnt clears on entry to GRANTx and increments each GRANTx cycle with s_waitrequest=1.
  - When wait_cnt == TIMEOUT_CYCLES-1 and s_waitrequest is still 1:
    - mX_waitrequest forced 0 and mX_readdata forced 0 that cycle
    - s_read/s_write still asserted that cycle
    - timeout_err=1 for exactly that cycle
    - next state IDLE
  - wait_cnt width is $clog2(TIMEOUT_CYCLES+1). No wrap is possible because the abort precedes overflow.
- Reset (reset=0, asynchronous, any state including mid-transaction):
  - state=IDLE, last=RESET_LAST, wait_cnt=0
  - grant=0, timeout_err=0, s_read=s_write=0, both waitrequest=1
  - An in-flight slave access is abandoned.
- Reset release: first arbitration on the first rising edge with reset=1.

Decomposition:
- Shared package mips_bus_pkg:
  - arb_state_t enum {IDLE, GRANT0, GRANT1}
  - bus width constants ADDR_W=32, DATA_W=32, BE_W=4
  - readdata value used on timeout abort (32'h0)
- One natural sub-module: mips_bus_rr_pick, a combinational 2-way round-robin selector (req[1:0], last -> pick, valid).
- State, counter and muxing stay in mips_bus_arbiter.

Test Plan:
- Reset mid-transaction: hold reset=0 while GRANT1 with s_waitrequest=1 -> same cycle grant=0, s_read=0, m1_waitrequest=1; after release, M0 request at 0xBFC00000 is granted next cycle.
- Single master: M0 read at 0xBFC00000, slave zero-wait returns 0x24020005 -> s_read high 1 cycle later, m0_readdata=0x24020005 with m0_waitrequest=0 that cycle, then IDLE.
- Tie round-robin: both request continuously, zero-wait slave -> grants alternate 01,00,10,00,01... starting with M0 (RESET_LAST=1).
- Wait states: M1 write addr 0x00001000, data 0xDEADBEEF, byteenable 4'b0011, slave waits 3 cycles -> s_* stable 4 cycles, m1_waitrequest mirrors slave, m0_waitrequest=1 throughout.
- Timeout: TIMEOUT_CYCLES=4, slave holds waitrequest=1 forever -> on 4th granted cycle timeout_err=1 for one cycle, m0_waitrequest=0, m0_readdata=0, then IDLE.
- Request drop: M0 deasserts read while granted and slave stalled -> IDLE next cycle, timeout_err stays 0, a pending M1 request is granted the cycle after.
